// File: rtl/yarp_pkg.sv
// Shared types for the YARP data-memory path.
//   mem_access_size_e : access size encoding carried on data_mem_byte_en_i
//   dmem_state_e      : responder FSM states
//   dmem_req_t        : request fields captured on the grant cycle
//   size_misaligned() : alignment / reserved-size error for one access
//   size_lane_mask()  : per-lane write enable for one access
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_e;

    typedef struct packed {
        logic [31:0]      addr;
        mem_access_size_e size;
        logic             wr;
        logic [31:0]      wr_data;
    } dmem_req_t;

    // Reserved size 2'b10 is reported as an error alongside misalignment.
    function automatic logic size_misaligned(input mem_access_size_e size,
                                             input logic [1:0] lane);
        logic bad;
        case (size)
            BYTE:      bad = 1'b0;
            HALF_WORD: bad = lane[0];
            WORD:      bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] size_lane_mask(input mem_access_size_e size,
                                                  input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            BYTE:      mask = 4'b0001 << lane;
            HALF_WORD: mask = lane[1] ? 4'b1100 : 4'b0011;
            WORD:      mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/yarp_dmem_array.sv
// Word-organised data storage with per-byte-lane write enables.
//   clk   : write clock
//   we    : one enable per byte lane, committed on the rising edge
//   addr  : word index shared by read and write
//   wdata : lane-replicated write data
//   rdata : combinational read of the addressed word
module yarp_dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset; contents are undefined until written, which
    // keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/yarp_dmem_responder.sv
// Data-memory responder: grants one request at a time, optionally waits
// WAIT_STATES cycles, then returns a single-cycle response.
//   clk, reset          : clock, synchronous active-high reset
//   data_mem_req_i      : request valid, held by the initiator until granted
//   data_mem_addr_i     : byte address
//   data_mem_byte_en_i  : access size
//   data_mem_wr_i       : 1 = write, 0 = read
//   data_mem_wr_data_i  : right-justified write data
//   mem_gnt_o           : request accepted this cycle
//   mem_rvalid_o        : one-cycle response strobe
//   mem_rd_data_o       : right-justified read data, zero otherwise
//   mem_err_o           : access error, qualified by mem_rvalid_o
module yarp_dmem_responder
    import yarp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_mem_req_i,
    input  logic [31:0]      data_mem_addr_i,
    input  mem_access_size_e data_mem_byte_en_i,
    input  logic             data_mem_wr_i,
    input  logic [31:0]      data_mem_wr_data_i,
    output logic             mem_gnt_o,
    output logic             mem_rvalid_o,
    output logic [31:0]      mem_rd_data_o,
    output logic             mem_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    dmem_state_e state, state_nxt;
    logic [2:0]  wait_cnt, wait_cnt_nxt;
    dmem_req_t   req_q;

    logic [1:0]  lane;
    logic        access_err;
    logic        in_resp;
    logic [3:0]  arr_we;
    logic [31:0] arr_wdata;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rd_just;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Request fields are only consumed while a transaction is in flight, so
    // they need no reset.
    always_ff @(posedge clk) begin
        if (mem_gnt_o) begin
            req_q <= '{addr:    data_mem_addr_i,
                       size:    data_mem_byte_en_i,
                       wr:      data_mem_wr_i,
                       wr_data: data_mem_wr_data_i};
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (data_mem_req_i) begin
                    wait_cnt_nxt = 3'd0;
                    state_nxt    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath derived from the captured request.
    assign lane       = req_q.addr[1:0];
    assign access_err = size_misaligned(req_q.size, lane)
                      | ((req_q.addr >> (AW + 2)) != 32'd0);
    assign rd_shift   = rd_word >> {lane, 3'b000};

    always_comb begin
        case (req_q.size)
            BYTE:      rd_just = {24'h0, rd_shift[7:0]};
            HALF_WORD: rd_just = {16'h0, rd_shift[15:0]};
            default:   rd_just = rd_word;
        endcase
    end

    // Replicate write data so each lane sees its bytes regardless of offset.
    always_comb begin
        case (req_q.size)
            BYTE:      arr_wdata = {4{req_q.wr_data[7:0]}};
            HALF_WORD: arr_wdata = {2{req_q.wr_data[15:0]}};
            default:   arr_wdata = req_q.wr_data;
        endcase
    end

    // Outputs. Reset gates the response and the write commit in the same
    // cycle, so a transaction caught by reset leaves no trace.
    always_comb begin
        in_resp       = (state == ST_RESP) && !reset;
        mem_gnt_o     = (state == ST_IDLE) && !reset && data_mem_req_i;
        mem_rvalid_o  = in_resp;
        mem_err_o     = in_resp && access_err;
        mem_rd_data_o = (in_resp && !req_q.wr && !access_err) ? rd_just : 32'd0;
        arr_we        = (in_resp && req_q.wr && !access_err)
                      ? size_lane_mask(req_q.size, lane) : 4'b0000;
    end

    yarp_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (req_q.addr[2 +: AW]),
        .wdata (arr_wdata),
        .rdata (rd_word)
    );

endmodule

// File: doc/yarp_dmem_responder.md
YARP_DMEM_RESPONDER -- requirements
Module: yarp_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra cycles (0..7) inserted before each response.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_mem_req_i  input  1  request valid from the data-memory initiator.
REQ-006 SHALL have port data_mem_addr_i  input  32  byte address.
REQ-007 SHALL have port data_mem_byte_en_i  input  2  access size, type mem_access_size_e.
REQ-008 SHALL have port data_mem_wr_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port data_mem_wr_data_i  input  32  right-justified write data.
REQ-010 SHALL have port mem_gnt_o  output  1  request accepted this cycle.
REQ-011 SHALL have port mem_rvalid_o  output  1  one-cycle response strobe.
REQ-012 SHALL have port mem_rd_data_o  output  32  right-justified read data, upper bits zero.
REQ-013 SHALL have port mem_err_o  output  1  access error, valid with mem_rvalid_o.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_STATES = 0.
REQ-015 SHALL drive mem_gnt_o = data_mem_req_i only in IDLE; 0 in WAIT and RESP.
REQ-016 SHALL register addr, size, wr, wr_data on the grant cycle; initiator holds the request until granted.
REQ-017 SHALL count WAIT_STATES cycles in WAIT with a 3-bit counter, then enter RESP.
REQ-018 SHALL assert mem_rvalid_o for exactly the RESP cycle; granted in cycle N -> rvalid in cycle N+1+WAIT_STATES.
REQ-019 SHALL accept the next request no earlier than the cycle after RESP.
REQ-020 SHALL define sizes: BYTE = 2'b00, HALF_WORD = 2'b01, WORD = 2'b11; 2'b10 is reserved.
REQ-021 SHALL select the word via addr[2 +: log2(DEPTH_WORDS)] and the lane via addr[1:0].
REQ-022 SHALL steer writes by size: BYTE writes wr_data[7:0] to lane addr[1:0]; HALF_WORD writes wr_data[15:0] to lanes {addr[1],0},{addr[1],1}; WORD writes all lanes.
REQ-023 SHALL commit writes in the RESP cycle; other lanes SHALL be unchanged.
REQ-024 SHALL return reads right-justified: BYTE -> {24'h0, lane}, HALF_WORD -> {16'h0, half}, WORD -> full word.
REQ-025 SHALL flag an error when any of these hold: HALF_WORD with addr[0] = 1, WORD with addr[1:0] != 0, reserved size, or addr >= 4*DEPTH_WORDS.
REQ-026 SHALL on error suppress the write, drive mem_rd_data_o = 0, and assert mem_err_o with mem_rvalid_o.
REQ-027 SHALL drive mem_rd_data_o = 0 and mem_err_o = 0 whenever mem_rvalid_o = 0, and for write responses.
REQ-028 SHALL guarantee that a read following a write to the same address returns the newly written data.

Reset
REQ-029 SHALL on reset force IDLE, counter = 0, mem_rvalid_o = 0, mem_err_o = 0, mem_rd_data_o = 0.
REQ-030 SHALL on reset asserted in WAIT or RESP abort the transaction: no write commit and no rvalid.
REQ-031 SHALL leave storage contents unaffected by reset; they are undefined until written.
REQ-032 SHALL drive mem_gnt_o = 0 in any cycle where reset = 1.

Structure
REQ-033 SHALL take mem_access_size_e from yarp_pkg; the FSM state enum SHALL be added to yarp_pkg as dmem_state_e.
REQ-034 SHALL place the storage in sub-module yarp_dmem_array: DEPTH_WORDS x 32, 4-bit lane write-enable, combinational read.

Verification
REQ-035 SHALL cover WAIT_STATES = 0: WORD write 0xDEADBEEF @0x10, then WORD read @0x10 -> rvalid one cycle after grant, data 0xDEADBEEF, err = 0.
REQ-036 SHALL cover byte steering: BYTE write 0xA5 @0x13 over 0x11223344 -> word becomes 0xA5223344; BYTE read @0x13 -> 0x000000A5.
REQ-037 SHALL cover halfword access: HALF_WORD read @0x12 of 0xA5223344 -> 0x0000A522; HALF_WORD write @0x11 -> err = 1, word unchanged.
REQ-038 SHALL cover WAIT_STATES = 3: grant cycle N -> rvalid in cycle N+4; req held during busy cycles -> gnt = 0 until IDLE.
REQ-039 SHALL cover range and size errors: addr 0x1000 with DEPTH_WORDS = 1024 -> err = 1, data 0; size 2'b10 -> err = 1.
REQ-040 SHALL cover reset mid-operation: reset asserted in the WAIT cycle of a write -> no rvalid, target word retains its old value.
